// File: rtl/scan_pkg.sv
// ============================================================================
// scan_pkg : shared types and constants for the scan sequencer - Rev 1.0
// ============================================================================
`default_nettype none

package scan_pkg;
    localparam int IDX_W        = 3;
    localparam int MAX_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        ACTIVE = 2'd2
    } scan_state_t;
endpackage

`default_nettype wire

// File: rtl/scan_timer.sv
// ============================================================================
// scan_timer : loadable down-counter with final and next-to-final flags - Rev 1.0
// ============================================================================
`default_nettype none

module scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done,
    output logic             almost_done
);
    logic [WIDTH-1:0] r_count;

    // Loaded with N-1 so a phase lasts N cycles and its last cycle reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done        = (r_count == '0);
    assign almost_done = (r_count == WIDTH'(1));
endmodule

`default_nettype wire

// File: rtl/scan_sequencer.sv
// ============================================================================
// scan_sequencer : dwell/blank channel sequencer for a 3-to-8 decoder - Rev 1.0
// ============================================================================
`default_nettype none

module scan_sequencer
    import scan_pkg::*;
#(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [IDX_W-1:0]   last,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               en,
    output logic               busy,
    output logic               ch_done,
    output logic               frame_done
);
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int TIMER_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;
    localparam bit c_no_blank = (BLANK_CYCLES == 0);
    localparam logic [TIMER_W-1:0] c_blank_load =
        TIMER_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t        r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_stop_pending;
    logic               r_en;
    logic               r_busy;
    logic               r_ch_done;
    logic               r_frame_done;

    logic               w_t_done;
    logic               w_t_almost;
    logic               w_final;
    logic               w_stop_now;
    logic               w_start_ok;
    logic               w_go_idle;
    logic               w_go_blank;
    logic               w_go_active;
    logic               w_dwell_one;
    logic [IDX_W-1:0]   w_idx_next;
    logic [TIMER_W-1:0] w_dwell_load;
    logic [TIMER_W-1:0] w_load_value;

    always_comb begin
        w_final     = (r_state == ACTIVE) && w_t_done;
        w_stop_now  = stop || r_stop_pending;
        w_start_ok  = (r_state == IDLE) && start && !stop;
        w_go_idle   = ((r_state == BLANK) && stop) || (w_final && w_stop_now);
        w_go_blank  = !c_no_blank && (w_start_ok || (w_final && !w_stop_now));
        w_go_active = (c_no_blank && (w_start_ok || (w_final && !w_stop_now)))
                    || ((r_state == BLANK) && !stop && w_t_done);
        // Wrap follows the registered frame_done so the pulse and the wrap always agree.
        w_idx_next   = w_final ? (r_frame_done ? '0 : r_idx + 3'd1) : r_idx;
        w_dwell_one  = (dwell <= DWELL_W'(1));
        w_dwell_load = (dwell == '0) ? '0 : TIMER_W'(dwell - 1'b1);
        w_load_value = w_go_active ? w_dwell_load : c_blank_load;
    end

    scan_timer #(
        .WIDTH (TIMER_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (w_go_blank || w_go_active),
        .load_value  (w_load_value),
        .done        (w_t_done),
        .almost_done (w_t_almost)
    );

    // Pulses are predicted one edge early so they land on the final enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_idx          <= '0;
            r_stop_pending <= 1'b0;
            r_en           <= 1'b0;
            r_busy         <= 1'b0;
            r_ch_done      <= 1'b0;
            r_frame_done   <= 1'b0;
        end else begin
            r_ch_done    <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_go_idle) begin
                r_state        <= IDLE;
                r_idx          <= '0;
                r_stop_pending <= 1'b0;
                r_en           <= 1'b0;
                r_busy         <= 1'b0;
            end else if (w_go_blank) begin
                r_state <= BLANK;
                r_idx   <= w_idx_next;
                r_en    <= 1'b0;
                r_busy  <= 1'b1;
            end else if (w_go_active) begin
                r_state      <= ACTIVE;
                r_idx        <= w_idx_next;
                r_en         <= 1'b1;
                r_busy       <= 1'b1;
                r_ch_done    <= w_dwell_one;
                r_frame_done <= w_dwell_one && (w_idx_next == last);
            end else if (r_state == ACTIVE) begin
                if (stop) begin
                    r_stop_pending <= 1'b1;
                end
                if (w_t_almost) begin
                    r_ch_done    <= 1'b1;
                    r_frame_done <= (r_idx == last);
                end
            end
        end
    end

    assign a          = r_idx[2];
    assign b          = r_idx[1];
    assign c          = r_idx[0];
    assign en         = r_en;
    assign busy       = r_busy;
    assign ch_done    = r_ch_done;
    assign frame_done = r_frame_done;
endmodule

`default_nettype wire

// File: tb/tb_scan_sequencer.sv
// ============================================================================
// tb_scan_sequencer : directed self-checking bench for scan_sequencer - Rev 1.0
// ============================================================================
`default_nettype none

module tb_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start = 1'b0, stop = 1'b0;
    logic [2:0]  last = 3'd0;
    logic [15:0] dwell = 16'd0;
    logic        a, b, c, en, busy, ch_done, frame_done;

    logic        start0 = 1'b0, stop0 = 1'b0;
    logic [2:0]  last0 = 3'd0;
    logic [15:0] dwell0 = 16'd0;
    logic        a0, b0, c0, en0, busy0, ch0, fd0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] exp_idx [6] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd1};
    logic       exp_fd  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .last(last), .dwell(dwell),
        .a(a), .b(b), .c(c), .en(en), .busy(busy), .ch_done(ch_done), .frame_done(frame_done)
    );

    scan_sequencer #(.DWELL_W(16), .BLANK_CYCLES(0)) u_dut_nb (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .last(last0), .dwell(dwell0),
        .a(a0), .b(b0), .c(c0), .en(en0), .busy(busy0), .ch_done(ch0), .frame_done(fd0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        // Reset held and released
        tick(); tick();
        chk("rst_idx", {a, b, c}, 0);
        chk("rst_en", en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulses", {ch_done, frame_done}, 0);
        chk("rst_nb_busy", busy0, 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // last=3, dwell=4: 6-cycle channel period, frame of 24
        last = 3'd3; dwell = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 25; t++) begin
            chk("t1_busy", busy, 1);
            chk("t1_en", en, (t % 6) >= 2);
            chk("t1_idx", {a, b, c}, (t / 6) % 4);
            chk("t1_ch", ch_done, (t % 6) == 5);
            chk("t1_fd", frame_done, ((t % 6) == 5) && (((t / 6) % 4) == 3));
            tick();
        end
        // Still in the blanking gap before channel 0: stop drops straight to idle
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("blank_stop_busy", busy, 0);
        chk("blank_stop_en", en, 0);
        chk("blank_stop_pulse", {ch_done, frame_done}, 0);
        tick();
        chk("blank_stop_en2", en, 0);

        // dwell=0 behaves as 1, single channel frame
        last = 3'd0; dwell = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 9; t++) begin
            chk("t2_en", en, (t % 3) == 2);
            chk("t2_ch", ch_done, (t % 3) == 2);
            chk("t2_fd", frame_done, (t % 3) == 2);
            chk("t2_idx", {a, b, c}, 0);
            tick();
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t2_stop_busy", busy, 0);

        // stop during channel 2 of dwell=10: channel finishes all 10 cycles
        last = 3'd3; dwell = 16'd10; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (28) tick();
        chk("t3_mid_en", en, 1);
        chk("t3_mid_idx", {a, b, c}, 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_after_stop_en", en, 1);
        chk("t3_after_stop_busy", busy, 1);
        repeat (6) tick();
        chk("t3_final_en", en, 1);
        chk("t3_final_ch", ch_done, 1);
        chk("t3_final_fd", frame_done, 0);
        chk("t3_final_idx", {a, b, c}, 2);
        tick();
        chk("t3_idle_busy", busy, 0);
        chk("t3_idle_en", en, 0);
        chk("t3_idle_idx", {a, b, c}, 0);
        chk("t3_idle_ch", ch_done, 0);

        // start and stop together in idle: nothing happens
        dwell = 16'd4; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        chk("t4_both_busy", busy, 0);
        tick();
        chk("t4_both_en", en, 0);

        // start while busy is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("t4_en_t3", en, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_en_t4", en, 1);
        chk("t4_idx_t4", {a, b, c}, 0);
        tick();
        chk("t4_ch_t5", ch_done, 1);
        tick();
        chk("t4_en_t6", en, 0);
        chk("t4_idx_t6", {a, b, c}, 1);
        repeat (2) tick();
        chk("t4_en_t8", en, 1);
        chk("t4_idx_t8", {a, b, c}, 1);

        // reset in the middle of channel 4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last = 3'd7; dwell = 16'd4; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        chk("t6_pre_idx", {a, b, c}, 4);
        chk("t6_pre_en", en, 1);
        rst = 1'b1;
        tick();
        chk("t6_rst_en", en, 0);
        chk("t6_rst_idx", {a, b, c}, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_pulses", {ch_done, frame_done}, 0);
        tick();
        chk("t6_rst_ch2", ch_done, 0);
        rst = 1'b0;
        tick();
        chk("t6_post_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_restart_busy", busy, 1);
        chk("t6_restart_en", en, 0);
        repeat (2) tick();
        chk("t6_restart_en2", en, 1);
        chk("t6_restart_idx", {a, b, c}, 0);

        // No-blank build: index advances every cycle, then last lowered mid-frame
        last0 = 3'd7; dwell0 = 16'd1; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 13; t++) begin
            chk("t5_en", en0, 1);
            chk("t5_ch", ch0, 1);
            chk("t5_idx", {a0, b0, c0}, t % 8);
            chk("t5_fd", fd0, (t % 8) == 7);
            tick();
        end
        chk("t5_idx5", {a0, b0, c0}, 5);
        last0 = 3'd1;
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("t5_low_idx", {a0, b0, c0}, exp_idx[k]);
            chk("t5_low_fd", fd0, exp_fd[k]);
            chk("t5_low_en", en0, 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
